perip_bridge: RTL and testbench

PERIP_BRIDGE -- requirements
Module: perip_bridge

---
 rtl/perip_pkg.sv | 57 +++++
 rtl/perip_dram.sv | 34 +++
 rtl/perip_bridge.sv | 143 ++++++++++++++
 tb/tb_perip_bridge.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/perip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perip_pkg
//  Description : Address map, access encodings, counter commands and state
//                type shared by the peripheral bridge.
//  Revision    : 1.0  initial release
// ============================================================================
package perip_pkg;

    localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
    localparam logic [31:0] PERIP_BASE = 32'h8020_0000;
    localparam logic [31:0] PERIP_LIMIT = 32'h8020_00FF;

    localparam logic [7:0] OFS_SW  = 8'h00;
    localparam logic [7:0] OFS_KEY = 8'h10;
    localparam logic [7:0] OFS_SEG = 8'h20;
    localparam logic [7:0] OFS_LED = 8'h40;
    localparam logic [7:0] OFS_CNT = 8'h50;

    localparam logic [31:0] SW_ADDR  = PERIP_BASE | {24'h0, OFS_SW};
    localparam logic [31:0] KEY_ADDR = PERIP_BASE | {24'h0, OFS_KEY};
    localparam logic [31:0] SEG_ADDR = PERIP_BASE | {24'h0, OFS_SEG};
    localparam logic [31:0] LED_ADDR = PERIP_BASE | {24'h0, OFS_LED};
    localparam logic [31:0] CNT_ADDR = PERIP_BASE | {24'h0, OFS_CNT};

    localparam logic [1:0] MASK_B = 2'b00;
    localparam logic [1:0] MASK_H = 2'b01;
    localparam logic [1:0] MASK_W = 2'b11;

    localparam logic [31:0] CMD_RUN  = 32'h8000_0000;
    localparam logic [31:0] CMD_HOLD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        CNT_IDLE = 2'd0,
        CNT_RUN  = 2'd1,
        CNT_HOLD = 2'd2
    } cnt_state_t;

    // Misaligned half/word accesses yield no lanes, which drops the write.
    function automatic logic [3:0] lane_en(input logic [1:0] mask, input logic [1:0] lo);
        case (mask)
            MASK_B:  lane_en = 4'b0001 << lo;
            MASK_H:  lane_en = lo[0] ? 4'b0000 : (lo[1] ? 4'b1100 : 4'b0011);
            default: lane_en = (lo == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] mask, input logic [31:0] wdata);
        case (mask)
            MASK_B:  lane_data = {4{wdata[7:0]}};
            MASK_H:  lane_data = {2{wdata[15:0]}};
            default: lane_data = wdata;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/perip_dram.sv
`default_nettype none
// ============================================================================
//  Module      : perip_dram
//  Description : Single-port data RAM, 4 byte-lane write enables, registered
//                read-first output.
//  Revision    : 1.0  initial release
// ============================================================================
module perip_dram #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:(1<<AW)-1];
    logic [31:0] r_rdata;

    // Contents are intentionally never reset; the read sees pre-write data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/perip_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : perip_bridge
//  Description : CPU data-bus bridge to data RAM, switches, keys, LEDs,
//                7-segment register and a prescaled run/hold counter.
//  Revision    : 1.0  initial release
// ============================================================================
module perip_bridge
    import perip_pkg::*;
#(
    parameter int DRAM_AW = 14,
    parameter int CNT_DIV = 50000
) (
    input  logic        w_cpu_clk,
    input  logic        w_clk_rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [1:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    input  logic [31:0] sw,
    input  logic [7:0]  key,
    output logic [31:0] led,
    output logic [31:0] seg_data
);

    localparam logic [32:0] c_dram_size = 33'd4 << DRAM_AW;
    localparam logic [23:0] c_div_max   = 24'(CNT_DIV - 1);

    logic [31:0] w_dram_off;
    logic        w_dram_hit;
    logic        w_hit_sw, w_hit_key, w_hit_seg, w_hit_led, w_hit_cnt;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [3:0]  w_dram_we;
    logic [31:0] w_dram_q;
    logic [31:0] w_rd;
    logic        w_cnt_cmd;

    logic [31:0] r_sw_s1, r_sw_s2;
    logic [7:0]  r_key_s1, r_key_s2;
    logic [31:0] r_led, r_seg;
    logic [31:0] r_rd_q;
    logic        r_sel_dram;
    logic [31:0] r_count;
    logic [23:0] r_presc;
    cnt_state_t  r_state;

    // Below-base addresses wrap to a huge offset and fall out of range.
    assign w_dram_off = perip_addr - DRAM_BASE;
    assign w_dram_hit = ({1'b0, w_dram_off} < c_dram_size);
    assign w_hit_sw   = (perip_addr[31:2] == SW_ADDR[31:2]);
    assign w_hit_key  = (perip_addr[31:2] == KEY_ADDR[31:2]);
    assign w_hit_seg  = (perip_addr[31:2] == SEG_ADDR[31:2]);
    assign w_hit_led  = (perip_addr[31:2] == LED_ADDR[31:2]);
    assign w_hit_cnt  = (perip_addr[31:2] == CNT_ADDR[31:2]);

    assign w_be      = lane_en(perip_mask, perip_addr[1:0]);
    assign w_wdata   = lane_data(perip_mask, perip_wdata);
    assign w_dram_we = (perip_wen && w_dram_hit) ? w_be : 4'b0000;
    assign w_cnt_cmd = perip_wen && w_hit_cnt && (w_be == 4'b1111);

    perip_dram #(
        .AW (DRAM_AW)
    ) u_dram (
        .clk     (w_cpu_clk),
        .i_we    (w_dram_we),
        .i_addr  (w_dram_off[DRAM_AW+1:2]),
        .i_wdata (w_wdata),
        .o_rdata (w_dram_q)
    );

    always_comb begin
        w_rd = 32'h0000_0000;
        if (w_hit_sw) begin
            w_rd = r_sw_s2;
        end else if (w_hit_key) begin
            w_rd = {24'h0, r_key_s2};
        end else if (w_hit_seg) begin
            w_rd = r_seg;
        end else if (w_hit_led) begin
            w_rd = r_led;
        end else if (w_hit_cnt) begin
            w_rd = r_count;
        end
    end

    always_ff @(posedge w_cpu_clk or posedge w_clk_rst) begin
        if (w_clk_rst) begin
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_key_s1   <= '0;
            r_key_s2   <= '0;
            r_led      <= '0;
            r_seg      <= '0;
            r_rd_q     <= '0;
            r_sel_dram <= 1'b0;
        end else begin
            r_sw_s1    <= sw;
            r_sw_s2    <= r_sw_s1;
            r_key_s1   <= key;
            r_key_s2   <= r_key_s1;
            r_rd_q     <= w_rd;
            r_sel_dram <= w_dram_hit;
            for (int i = 0; i < 4; i++) begin
                if (perip_wen && w_hit_led && w_be[i]) begin
                    r_led[8*i +: 8] <= w_wdata[8*i +: 8];
                end
                if (perip_wen && w_hit_seg && w_be[i]) begin
                    r_seg[8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // A command on a wrap edge takes priority over the increment.
    always_ff @(posedge w_cpu_clk or posedge w_clk_rst) begin
        if (w_clk_rst) begin
            r_state <= CNT_IDLE;
            r_count <= '0;
            r_presc <= '0;
        end else if (w_cnt_cmd && (perip_wdata == CMD_RUN)) begin
            r_state <= CNT_RUN;
            r_count <= '0;
            r_presc <= '0;
        end else if (w_cnt_cmd && (perip_wdata == CMD_HOLD) && (r_state == CNT_RUN)) begin
            r_state <= CNT_HOLD;
        end else if (r_state == CNT_RUN) begin
            if (r_presc == c_div_max) begin
                r_presc <= '0;
                r_count <= r_count + 32'd1;
            end else begin
                r_presc <= r_presc + 24'd1;
            end
        end
    end

    assign perip_rdata = r_sel_dram ? w_dram_q : r_rd_q;
    assign led         = r_led;
    assign seg_data    = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_perip_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perip_bridge
//  Description : Directed self-checking bench for perip_bridge (CNT_DIV = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_perip_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic [1:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] sw;
    logic [7:0]  key;
    logic [31:0] led;
    logic [31:0] seg;

    int n_total = 0;
    int n_bad   = 0;

    perip_bridge #(
        .DRAM_AW (14),
        .CNT_DIV (4)
    ) dut (
        .w_cpu_clk   (clk),
        .w_clk_rst   (rst),
        .perip_addr  (addr),
        .perip_wen   (wen),
        .perip_mask  (mask),
        .perip_wdata (wdata),
        .perip_rdata (rdata),
        .sw          (sw),
        .key         (key),
        .led         (led),
        .seg_data    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        addr  = a;
        mask  = m;
        wdata = d;
        wen   = 1'b1;
        tick;
        wen   = 1'b0;
        addr  = 32'h0000_0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        mask = 2'b11;
        wen  = 1'b0;
        tick;
        d = rdata;
    endtask

    logic [31:0] v;

    initial begin
        rst = 1'b1; addr = '0; wen = 1'b0; mask = 2'b11; wdata = '0; sw = '0; key = '0;
        repeat (3) tick;
        chk("rst_led", led, 32'h0);
        chk("rst_seg", seg, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b0;
        tick;

        // DRAM byte merge and read latency
        wr(32'h8010_0004, 2'b11, 32'h1122_3344);
        wr(32'h8010_0006, 2'b00, 32'h0000_00AA);
        rd(32'h8010_0004, v); chk("sb_merge", v, 32'h11AA_3344);

        // read-first on same-word write
        addr = 32'h8010_0004; mask = 2'b11; wdata = 32'hDEAD_BEEF; wen = 1'b1;
        tick;
        chk("rd_first", rdata, 32'h11AA_3344);
        wen = 1'b0;
        rd(32'h8010_0004, v); chk("rd_after_wr", v, 32'hDEAD_BEEF);

        // halfword lanes and misaligned drops
        wr(32'h8010_0000, 2'b11, 32'h1234_5678);
        wr(32'h8010_0002, 2'b01, 32'h0000_BEEF);
        wr(32'h8010_0003, 2'b01, 32'h0000_1111);
        wr(32'h8010_0001, 2'b11, 32'h0000_0000);
        rd(32'h8010_0000, v); chk("sh_hi_misalign", v, 32'hBEEF_5678);
        wr(32'h8010_0000, 2'b01, 32'h0000_CAFE);
        rd(32'h8010_0000, v); chk("sh_lo", v, 32'hBEEF_CAFE);
        wr(32'h8010_0010, 2'b10, 32'hCAFE_F00D);
        rd(32'h8010_0010, v); chk("mask10_word", v, 32'hCAFE_F00D);

        // DRAM range boundaries
        wr(32'h8010_FFFC, 2'b11, 32'h600D_F00D);
        rd(32'h8010_FFFC, v); chk("dram_last", v, 32'h600D_F00D);
        wr(32'h8011_0000, 2'b11, 32'h1212_1212);
        rd(32'h8011_0000, v); chk("dram_past_end", v, 32'h0);
        rd(32'h8010_0000, v); chk("no_alias", v, 32'hBEEF_CAFE);
        rd(32'h800F_FFFC, v); chk("below_base", v, 32'h0);

        // synchronized inputs and unmapped read
        sw = 32'hA5A5_0F0F; key = 8'h3C;
        repeat (3) tick;
        rd(32'h8020_0000, v); chk("sw_read", v, 32'hA5A5_0F0F);
        rd(32'h8020_0010, v); chk("key_read", v, 32'h0000_003C);
        rd(32'h9000_0000, v); chk("unmapped", v, 32'h0);
        sw = 32'h1234_5678;
        rd(32'h8020_0000, v); chk("sw_sync_old", v, 32'hA5A5_0F0F);
        tick;
        rd(32'h8020_0000, v); chk("sw_sync_new", v, 32'h1234_5678);

        // LED / SEG byte lanes
        wr(32'h8020_0041, 2'b00, 32'h0000_005A);
        chk("led_sb", led, 32'h0000_5A00);
        wr(32'h8020_0020, 2'b11, 32'h0102_0304);
        wr(32'h8020_0022, 2'b01, 32'h0000_ABCD);
        chk("seg_sh", seg, 32'hABCD_0304);
        rd(32'h8020_0020, v); chk("seg_read", v, 32'hABCD_0304);

        // counter: idle, hold ignored in idle
        rd(32'h8020_0050, v); chk("cnt_idle", v, 32'h0);
        wr(32'h8020_0050, 2'b11, 32'hFFFF_FFFF);
        repeat (10) tick;
        rd(32'h8020_0050, v); chk("cnt_hold_in_idle", v, 32'h0);

        // run 40 cycles then hold
        wr(32'h8020_0050, 2'b11, 32'h8000_0000);
        repeat (40) tick;
        wr(32'h8020_0050, 2'b11, 32'hFFFF_FFFF);
        rd(32'h8020_0050, v); chk("cnt_held", v, 32'd10);
        repeat (20) tick;
        rd(32'h8020_0050, v); chk("cnt_frozen", v, 32'd10);
        wr(32'h8020_0050, 2'b01, 32'h8000_0000);
        repeat (8) tick;
        rd(32'h8020_0050, v); chk("cnt_nonword_ign", v, 32'd10);

        // restart landing on a prescaler wrap edge
        wr(32'h8020_0050, 2'b11, 32'h8000_0000);
        repeat (3) tick;
        wr(32'h8020_0050, 2'b11, 32'h8000_0000);
        rd(32'h8020_0050, v); chk("cnt_cmd_wins", v, 32'h0);
        repeat (10) tick;
        rd(32'h8020_0050, v); chk("cnt_rerun", v, 32'd2);

        // asynchronous reset mid-cycle
        rd(32'h8020_0040, v); chk("led_read", v, 32'h0000_5A00);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_led", led, 32'h0);
        chk("arst_seg", seg, 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        repeat (2) tick;
        rst = 1'b0;
        tick;
        rd(32'h8020_0050, v); chk("arst_cnt", v, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
